// File: rtl/dsm_dec_pkg.sv
// Shared constants and width helpers for the delta-sigma CIC decoder.
package dsm_dec_pkg;

  localparam int CIC_ORDER = 3;

  // Register width that holds the full CIC gain R^N plus sign, so wrap is harmless.
  function automatic int cic_width(input int log2r);
    return 2 + CIC_ORDER * log2r;
  endfunction

  // Right shift that brings full scale R^N down to the output word.
  function automatic int cic_shift(input int log2r, input int out_w);
    return CIC_ORDER * log2r - (out_w - 1);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: delay register loaded on the decimation strobe, y = x - x_prev.
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] dly_q;
  logic [W-1:0] dly_d;

  always_comb begin
    dly_d = dly_q;
    if (en) dly_d = x;
    y = x - dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly_q <= '0;
    else        dly_q <= dly_d;
  end

endmodule

// File: rtl/dsm_bitstream_decoder.sv
// 1-bit delta-sigma to signed PCM decoder: 3rd-order CIC, decimation 2^LOG2R, scale and clamp.
// Optional DSM_DEC_OVF_EN adds the ovf port flagging clamped samples.
module dsm_bitstream_decoder
  import dsm_dec_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int LOG2R = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
`ifdef DSM_DEC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int W     = cic_width(LOG2R);
  localparam int SHIFT = cic_shift(LOG2R, OUT_W);
  localparam logic signed [W-1:0] SAT_MAX = W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [W-1:0] SAT_MIN = W'(-(64'sd1 <<< (OUT_W - 1)));

  logic [W-1:0]       s;
  logic [W-1:0]       i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [LOG2R-1:0]   phase_q, phase_d;
  logic [1:0]         warm_q, warm_d;
  logic               strobe;
  logic [W-1:0]       y_q, y_d;
  logic               pend_q, pend_d;
  logic signed [W-1:0] y_s;
  logic               clamp_hi, clamp_lo;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic [W-1:0]       comb_x [0:CIC_ORDER];

  assign comb_x[0] = i3_q;

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
    cic_comb_stage #(.W(W)) u_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (strobe),
      .x     (comb_x[g]),
      .y     (comb_x[g+1])
    );
  end

  // dout_valid is a one-cycle qualifier with no back-pressure: a consumer must
  // take dout on the pulse; dout also holds its value until the next pulse.
  always_comb begin
    s            = din ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    i1_d         = i1_q + s;
    i2_d         = i2_q + i1_q;
    i3_d         = i3_q + i2_q;
    phase_d      = phase_q + 1'b1;
    strobe       = (phase_q == {LOG2R{1'b1}});
    warm_d       = warm_q;
    y_d          = y_q;
    pend_d       = 1'b0;
    if (strobe) begin
      y_d    = comb_x[CIC_ORDER];
      pend_d = (warm_q == 2'd3);
      if (warm_q != 2'd3) warm_d = warm_q + 2'd1;
    end
    y_s          = $signed(y_q) >>> SHIFT;
    clamp_hi     = (y_s > SAT_MAX);
    clamp_lo     = (y_s < SAT_MIN);
    dout_d       = dout_q;
    dout_valid_d = pend_q;
    if (pend_q) begin
      if (clamp_hi)      dout_d = {1'b0, {(OUT_W-1){1'b1}}};
      else if (clamp_lo) dout_d = {1'b1, {(OUT_W-1){1'b0}}};
      else               dout_d = y_s[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      phase_q      <= '0;
      warm_q       <= '0;
      y_q          <= '0;
      pend_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      phase_q      <= phase_d;
      warm_q       <= warm_d;
      y_q          <= y_d;
      pend_q       <= pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef DSM_DEC_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = pend_q && (clamp_hi || clamp_lo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_dsm_bitstream_decoder.sv
// Bench for dsm_bitstream_decoder: reference is the closed-form CIC impulse response
// applied to the recorded input history, plus cadence, reset and loopback checks.
module tb_dsm_bitstream_decoder;

  localparam int OUT_W = 16;
  localparam int LOG2R = 6;
  localparam int R     = 1 << LOG2R;
  localparam int SHIFT = 3 * LOG2R - (OUT_W - 1);
  localparam int HLEN  = 3 * R + 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic [OUT_W-1:0] dout;
  logic dout_valid;
`ifdef DSM_DEC_OVF_EN
  logic ovf;
`endif

  always #5 clk = ~clk;

  dsm_bitstream_decoder #(.OUT_W(OUT_W), .LOG2R(LOG2R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
`ifdef DSM_DEC_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int h [0:HLEN-1];
  int s_hist[$];
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W-1:0] exp_last;
  int edges;
  int cur_mode;
  logic alt_bit;
  int mod_x, mod_i1, mod_i2;
  logic mod_bit;
  int loop_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  // Three cascaded integrators give i3(j) = sum s_m * g(j-m), g(d) = d(d-1)/2;
  // the three combs take the third difference at spacing R.
  function automatic int g_fn(input int d);
    return (d >= 2) ? d * (d - 1) / 2 : 0;
  endfunction

  task automatic build_kernel();
    int coef [0:3];
    coef[0] = 1; coef[1] = -3; coef[2] = 3; coef[3] = -1;
    for (int d = 0; d < HLEN; d++) begin
      h[d] = 0;
      for (int k = 0; k < 4; k++) h[d] += coef[k] * g_fn(d - k * R);
    end
  endtask

  task automatic start_segment();
    edges = 0;
    s_hist.delete();
    exp_q.delete();
    exp_last = '0;
  endtask

  function automatic logic next_bit(input int mode);
    int fb;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: begin alt_bit = ~alt_bit; return alt_bit; end
      3: return 1'($urandom_range(1, 0));
      default: begin
        fb = mod_bit ? 32768 : -32768;
        mod_i1 = mod_i1 + mod_x - fb;
        mod_i2 = mod_i2 + mod_i1 - fb;
        mod_bit = (mod_i2 >= 0);
        return mod_bit;
      end
    endcase
  endfunction

  // Called at the falling edge after `edges` rising edges since reset release.
  task automatic observe();
    logic exp_v;
    logic [OUT_W:0] item;
    int n, t, y, ys, lo, d;
    logic clamped;
    exp_v = (edges >= 4 * R + 1) && ((edges - 1) % R == 0);
    check_eq("valid", dout_valid, exp_v);
    if (exp_v) begin
      n = (edges - 1) / R;
      t = n * R - 1;
      lo = (t - HLEN + 1 > 1) ? t - HLEN + 1 : 1;
      y = 0;
      for (int m = lo; m <= t; m++) y += s_hist[m-1] * h[t-m];
      ys = y >>> SHIFT;
      clamped = 1'b0;
      if (ys > 32767)  begin ys = 32767;  clamped = 1'b1; end
      if (ys < -32768) begin ys = -32768; clamped = 1'b1; end
      exp_q.push_back({clamped, 16'(ys)});
    end
    if (dout_valid && exp_q.size() > 0) begin
      item = exp_q.pop_front();
      check_eq("dout", dout, item[OUT_W-1:0]);
`ifdef DSM_DEC_OVF_EN
      check_eq("ovf", ovf, item[OUT_W]);
`endif
      exp_last = item[OUT_W-1:0];
      if (cur_mode == 4) begin
        loop_cnt++;
        if (loop_cnt >= 5) begin
          d = int'($signed(dout)) - mod_x;
          if (d < 0) d = -d;
          check_eq("loop_tol", d <= 64, 1);
        end
      end
    end else begin
      check_eq("dout_hold", dout, exp_last);
`ifdef DSM_DEC_OVF_EN
      check_eq("ovf_idle", ovf, 1'b0);
`endif
    end
  endtask

  // driver: assumes entry at a falling edge
  task automatic run(input int ncyc, input int mode);
    cur_mode = mode;
    for (int i = 0; i < ncyc; i++) begin
      observe();
      din = next_bit(mode);
      s_hist.push_back(din ? 1 : -1);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic reset_mid();
    observe();
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", dout_valid, 1'b0);
    check_eq("rst_async_dout", dout, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_valid", dout_valid, 1'b0);
    rst_n = 1'b1;
    start_segment();
  endtask

  initial begin
    build_kernel();
    alt_bit = 1'b0;
    mod_x = 0; mod_i1 = 0; mod_i2 = 0; mod_bit = 1'b0;
    loop_cnt = 0;
    cur_mode = 0;
    start_segment();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_dout", dout, '0);
    check_eq("reset_valid", dout_valid, 1'b0);
`ifdef DSM_DEC_OVF_EN
    check_eq("reset_ovf", ovf, 1'b0);
`endif
    rst_n = 1'b1;

    // all ones from reset, then reset mid-stream while a pulse is high
    run(4 * R + 1 + R, 1);
    reset_mid();
    run(6 * R, 1);

    // all zeros, alternating, random density
    run(8 * R, 0);
    run(8 * R, 2);
    run(10 * R, 3);

    // loopback from a second-order modulator model
    mod_x = 16384; loop_cnt = 0;
    run(12 * R, 4);
    mod_x = -8192; loop_cnt = 0;
    run(12 * R, 4);

    // long cadence run: 1000 pulses of random bits
    run(1000 * R, 3);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsm_bitstream_decoder.md
# dsm_bitstream_decoder

Reconstructs signed 16-bit samples from the 1-bit second-order delta-sigma streams that drive the pinX/pinY/pinZ outputs. It uses a 3rd-order CIC decimator with a fixed decimation ratio of 2^LOG2R. It sits on the receive side of a DAC loopback: one instance per channel, fed from the pin (or the modulator output) in the same clock domain. Its outputs let the bench and on-chip monitors compare the decoded value against the modulator's `din`.

## Interface
- `OUT_W`, 16: output sample width. Matches the modulator input width.
- `LOG2R`, 6: log2 of the decimation ratio, so R = 64. Must equal the modulator's second parameter.
- `clk` input 1: single clock, the same clock that runs the modulator.
- `rst_n` input 1: reset, asynchronous, active-low.
- `din` input 1: delta-sigma bit. 1 means +1, 0 means -1.
- `dout` output OUT_W: decoded signed sample, two's complement.
- `dout_valid` output 1: one-cycle pulse when `dout` updates.
- `ovf` output 1: present only with `DSM_DEC_OVF_EN`. Qualified by `dout_valid`.

## Operation
- Internal width W = 2 + 3*LOG2R, which is 20 by default. All integrator and comb arithmetic wraps modulo 2^W. The wrap is intentional and correct for CIC; there is no saturation inside the filter.
- Input map: s = din ? +1 : -1, sign-extended to W bits.
- Integrators: three cascaded registered accumulators, i1 += s, i2 += i1, i3 += i2. All update every clk.
- Decimation counter `phase`, 0..R-1, increments every clk and wraps R-1 -> 0. The strobe is the cycle with phase == R-1.
- On a strobe, i3 is sampled into the comb section: three differentiators with delay 1 at the decimated rate, each with a one-word delay register that updates only on the strobe. The comb chain is combinational and its result is registered once.
- Gain is R^3 = 2^(3*LOG2R). The full-scale comb output is ±2^18.
- Scaling: y_s = y >>> (3*LOG2R - (OUT_W-1)), an arithmetic shift of 3 by default.
- Saturation: y_s is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. An all-ones stream therefore yields 32767 (clamped), and an all-zeros stream yields -32768 (exact).
- Settling counter `warm`, 0..3, increments on each strobe and saturates at 3. `dout_valid` is suppressed until warm == 3, so the first three decimated outputs are discarded.
- Reset values: all integrators, comb delays, `phase`, `warm`, `dout`, `dout_valid` and `ovf` are 0.

## Timing
- `dout`/`dout_valid` update on the clock edge after the strobe cycle, so latency from strobe to valid is 1 clk.
- After `rst_n` rises, the first strobe occurs on clock edge 64 and the first `dout_valid` on edge 257. Subsequent pulses come every 64 edges (R edges in general).
- `dout` holds its value between pulses. `dout_valid` is never high on two consecutive cycles.
- Reset asserted mid-operation clears all state immediately. `dout_valid` drops asynchronously, and the settling sequence restarts from zero.
- Group delay of the data path is about 1.5*R input bits plus 3 clk of integrator pipeline. The bench must not expect an edge-exact response to a step.

## Configuration
- `DSM_DEC_OVF_EN` defined: the `ovf` port exists. On each `dout_valid`, `ovf` = 1 if the value was clamped in that sample, else 0. `ovf` is 0 whenever `dout_valid` = 0.
- Not defined: the port and its logic are absent, and clamping still occurs.

## Structure
- Package `dsm_dec_pkg`: constants CIC_ORDER = 3, the function `cic_width(LOG2R)` = 2 + CIC_ORDER*LOG2R, and the function `cic_shift(LOG2R, OUT_W)`.
- One sub-module, `cic_comb_stage`: a W-bit delay register updated on the strobe enable, with a combinational difference output. It is instantiated 3 times.
- Integrators, counters and the scale/saturate logic live in the top module.

## Test plan
- Constant `din` = 1 from reset: first `dout_valid` on edge 257. Then `dout` = 32767 on every pulse, with `ovf` = 1 when enabled.
- Constant `din` = 0: `dout` = -32768 on every pulse, `ovf` = 0.
- Alternating 1,0,1,0 stream: `dout` = 0 on every pulse after settling.
- Loopback from `second_DSM_DAC #(16,6)` with `din` = 16'h4000, then -16'h2000: `dout` settles within ±64 LSB of 16384, then of -8192, within 4 pulses of each change.
- Assert `rst_n` low mid-stream for 3 clk during an all-ones run: `dout`/`dout_valid` are 0 immediately. The next valid is exactly 257 edges after release.
- Cadence check over 1000 pulses: exactly one `dout_valid` per 64 clk, with no back-to-back pulses.
